dp_ram_pipe: RTL and testbench

DP_RAM_PIPE -- requirements
Module: dp_ram_pipe

---
 rtl/dp_ram_pipe_if.sv | 28 ++
 rtl/dp_ram_pipe.sv | 154 +++++++++++++++
 tb/tb_dp_ram_pipe.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/dp_ram_pipe_if.sv
// One request/response port of dp_ram_pipe: request strobe, byte address,
// write data and lane enables in; response strobe, read data and range error out.
`ifndef RISCV_ADDR_WIDTH
`define RISCV_ADDR_WIDTH 32
`endif

interface dp_ram_pipe_if #(
    parameter int ADDR_WIDTH = `RISCV_ADDR_WIDTH,
    parameter int DATA_WIDTH = 32
);
    logic                    valid_i;
    logic [ADDR_WIDTH-1:0]   addr_i;
    logic [DATA_WIDTH-1:0]   wdata_i;
    logic [DATA_WIDTH/8-1:0] we_i;
    logic                    ready_o;
    logic [DATA_WIDTH-1:0]   rdata_o;
    logic                    err_o;

    modport master (
        output valid_i, addr_i, wdata_i, we_i,
        input  ready_o, rdata_o, err_o
    );

    modport slave (
        input  valid_i, addr_i, wdata_i, we_i,
        output ready_o, rdata_o, err_o
    );
endinterface

// File: rtl/dp_ram_pipe.sv
// Dual-port byte-writable RAM with a fixed LATENCY response pipeline per port.
// Optional macro DP_RAM_PIPE_FWD_EN forwards a same-cycle write from the other port into a read.
`ifndef RISCV_ADDR_WIDTH
`define RISCV_ADDR_WIDTH 32
`endif

module dp_ram_pipe #(
    parameter int ADDR_WIDTH = `RISCV_ADDR_WIDTH,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 262144,
    parameter int LATENCY    = 1
) (
    input  logic          clk,
    input  logic          rst,
    dp_ram_pipe_if.slave  a,
    dp_ram_pipe_if.slave  b,
    output logic          coll_o
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int OFF   = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);
    // Pipeline words: port A {valid, err, coll, data}; port B {valid, err, data}.
    localparam int PA    = DATA_WIDTH + 3;
    localparam int PB    = DATA_WIDTH + 2;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [ADDR_WIDTH-1:0] w_a_idx, w_b_idx;
    logic [IDX_W-1:0]      w_a_widx, w_b_widx;
    logic                  w_a_acc, w_b_acc, w_a_inr, w_b_inr, w_a_wr, w_b_wr, w_coll;
    logic [DATA_WIDTH-1:0] w_a_old, w_b_old, w_a_rd, w_b_rd;
    logic [PA-1:0]         w_a_req;
    logic [PB-1:0]         w_b_req;
    logic [PA-1:0]         r_a_pipe [LATENCY];
    logic [PB-1:0]         r_b_pipe [LATENCY];

    // Address decode, acceptance and same-word collision detection
    always_comb begin
        w_a_idx  = a.addr_i >> OFF;
        w_b_idx  = b.addr_i >> OFF;
        w_a_inr  = (w_a_idx < ADDR_WIDTH'(DEPTH));
        w_b_inr  = (w_b_idx < ADDR_WIDTH'(DEPTH));
        w_a_widx = w_a_idx[IDX_W-1:0];
        w_b_widx = w_b_idx[IDX_W-1:0];
        w_a_acc  = a.valid_i & ~rst;
        w_b_acc  = b.valid_i & ~rst;
        w_a_wr   = w_a_acc & w_a_inr & (|a.we_i);
        w_b_wr   = w_b_acc & w_b_inr & (|b.we_i);
        w_coll   = w_a_wr & w_b_wr & (w_a_idx == w_b_idx);
        w_a_old  = r_mem[w_a_widx];
        w_b_old  = r_mem[w_b_widx];
    end

`ifdef DP_RAM_PIPE_FWD_EN
    logic w_a_fwd, w_b_fwd;

    // Word as it will look after this cycle's writes; B owns lanes both ports enable.
    function automatic logic [DATA_WIDTH-1:0] merge_word(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [NB-1:0]         a_m,
        input logic [DATA_WIDTH-1:0] a_d,
        input logic [NB-1:0]         b_m,
        input logic [DATA_WIDTH-1:0] b_d
    );
        merge_word = old_w;
        for (int l = 0; l < NB; l++) begin
            if (b_m[l]) begin
                merge_word[8*l +: 8] = b_d[8*l +: 8];
            end else if (a_m[l]) begin
                merge_word[8*l +: 8] = a_d[8*l +: 8];
            end else begin
                merge_word[8*l +: 8] = old_w[8*l +: 8];
            end
        end
    endfunction

    // Cross-port forwarding of the merged write into a same-cycle read
    always_comb begin
        w_a_fwd = w_b_wr & w_a_acc & w_a_inr & (w_a_idx == w_b_idx);
        w_b_fwd = w_a_wr & w_b_acc & w_b_inr & (w_a_idx == w_b_idx);
        if (w_a_fwd) begin
            w_a_rd = merge_word(w_a_old, w_a_wr ? a.we_i : {NB{1'b0}}, a.wdata_i, b.we_i, b.wdata_i);
        end else begin
            w_a_rd = w_a_old;
        end
        if (w_b_fwd) begin
            w_b_rd = merge_word(w_b_old, a.we_i, a.wdata_i, w_b_wr ? b.we_i : {NB{1'b0}}, b.wdata_i);
        end else begin
            w_b_rd = w_b_old;
        end
    end
`else
    // Reads always see the word as it was before this cycle's writes
    always_comb begin
        w_a_rd = w_a_old;
        w_b_rd = w_b_old;
    end
`endif

    // Response words entering the pipeline
    always_comb begin
        w_a_req = {w_a_acc, w_a_acc & ~w_a_inr, w_coll, w_a_inr ? w_a_rd : {DATA_WIDTH{1'b0}}};
        w_b_req = {w_b_acc, w_b_acc & ~w_b_inr, w_b_inr ? w_b_rd : {DATA_WIDTH{1'b0}}};
    end

    // Byte-lane writes; port B is applied last so it wins shared lanes on a collision
    always_ff @(posedge clk) begin
        for (int l = 0; l < NB; l++) begin
            if (w_a_wr && a.we_i[l]) begin
                r_mem[w_a_widx][8*l +: 8] <= a.wdata_i[8*l +: 8];
            end
            if (w_b_wr && b.we_i[l]) begin
                r_mem[w_b_widx][8*l +: 8] <= b.wdata_i[8*l +: 8];
            end
        end
    end

    // Response shift registers; the last stage keeps its data between responses
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LATENCY; k++) begin
                r_a_pipe[k] <= {PA{1'b0}};
                r_b_pipe[k] <= {PB{1'b0}};
            end
        end else begin
            r_a_pipe[0][PA-1 -: 3] <= w_a_req[PA-1 -: 3];
            r_b_pipe[0][PB-1 -: 2] <= w_b_req[PB-1 -: 2];
            if ((LATENCY > 1) || w_a_req[PA-1]) begin
                r_a_pipe[0][DATA_WIDTH-1:0] <= w_a_req[DATA_WIDTH-1:0];
            end
            if ((LATENCY > 1) || w_b_req[PB-1]) begin
                r_b_pipe[0][DATA_WIDTH-1:0] <= w_b_req[DATA_WIDTH-1:0];
            end
            for (int k = 1; k < LATENCY; k++) begin
                r_a_pipe[k][PA-1 -: 3] <= r_a_pipe[k-1][PA-1 -: 3];
                r_b_pipe[k][PB-1 -: 2] <= r_b_pipe[k-1][PB-1 -: 2];
                if ((k < LATENCY - 1) || r_a_pipe[k-1][PA-1]) begin
                    r_a_pipe[k][DATA_WIDTH-1:0] <= r_a_pipe[k-1][DATA_WIDTH-1:0];
                end
                if ((k < LATENCY - 1) || r_b_pipe[k-1][PB-1]) begin
                    r_b_pipe[k][DATA_WIDTH-1:0] <= r_b_pipe[k-1][DATA_WIDTH-1:0];
                end
            end
        end
    end

    assign a.ready_o = r_a_pipe[LATENCY-1][PA-1];
    assign a.err_o   = r_a_pipe[LATENCY-1][PA-2];
    assign coll_o    = r_a_pipe[LATENCY-1][PA-3];
    assign a.rdata_o = r_a_pipe[LATENCY-1][DATA_WIDTH-1:0];
    assign b.ready_o = r_b_pipe[LATENCY-1][PB-1];
    assign b.err_o   = r_b_pipe[LATENCY-1][PB-2];
    assign b.rdata_o = r_b_pipe[LATENCY-1][DATA_WIDTH-1:0];
endmodule

// File: tb/tb_dp_ram_pipe.sv
// Table-driven scoreboard bench for dp_ram_pipe (LATENCY=3 instance) plus a
// LATENCY=4 instance exercising reset in the middle of an outstanding read.
module tb_dp_ram_pipe;
`ifdef DP_RAM_PIPE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        bit          av;  logic [31:0] aaddr; logic [31:0] awd; logic [3:0] awe;
        bit          bv;  logic [31:0] baddr; logic [31:0] bwd; logic [3:0] bwe;
        bit          ca;  logic [31:0] ea;    logic [31:0] ea_f; logic ea_err; logic ecoll;
        bit          cb;  logic [31:0] eb;    logic [31:0] eb_f; logic eb_err;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [31:0] rd;
        logic        err;
        logic        coll;
        bit          chk;
    } exp_t;

    logic clk = 1'b0;
    logic rst3, rst4, coll3, coll4;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t qa[$];
    exp_t qb[$];
    vec_t vt[12];
    bit   mon4_en = 1'b0;
    int   r4_cyc[$];
    logic [31:0] r4_dat[$];

    dp_ram_pipe_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ia3 ();
    dp_ram_pipe_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ib3 ();
    dp_ram_pipe_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ia4 ();
    dp_ram_pipe_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ib4 ();

    dp_ram_pipe #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(1024), .LATENCY(3)) u3 (
        .clk(clk), .rst(rst3), .a(ia3), .b(ib3), .coll_o(coll3));
    dp_ram_pipe #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(1024), .LATENCY(4)) u4 (
        .clk(clk), .rst(rst4), .a(ia4), .b(ib4), .coll_o(coll4));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv3(input vec_t v);
        ia3.valid_i = v.av; ia3.addr_i = v.aaddr; ia3.wdata_i = v.awd; ia3.we_i = v.awe;
        ib3.valid_i = v.bv; ib3.addr_i = v.baddr; ib3.wdata_i = v.bwd; ib3.we_i = v.bwe;
        if (v.av) qa.push_back('{cyc + 3, FWD ? v.ea_f : v.ea, v.ea_err, v.ecoll, v.ca});
        if (v.bv) qb.push_back('{cyc + 3, FWD ? v.eb_f : v.eb, v.eb_err, 1'b0, v.cb});
        tick();
        ia3.valid_i = 1'b0;
        ib3.valid_i = 1'b0;
    endtask

    // Scoreboard for the LATENCY=3 instance
    always @(negedge clk) begin
        exp_t e;
        if (rst3 === 1'b0) begin
            if (ia3.ready_o) begin
                if (qa.size() == 0) begin
                    chk("a_unexpected_ready", {31'd0, ia3.ready_o}, 32'd0);
                end else begin
                    e = qa.pop_front();
                    chk("a_ready_cycle", cyc, e.cyc);
                    chk("a_err", {31'd0, ia3.err_o}, {31'd0, e.err});
                    chk("a_coll", {31'd0, coll3}, {31'd0, e.coll});
                    if (e.chk) chk("a_rdata", ia3.rdata_o, e.rd);
                end
            end else begin
                chk("a_idle_flags", {30'd0, ia3.err_o, coll3}, 32'd0);
                if (qa.size() > 0 && qa[0].cyc <= cyc) begin
                    chk("a_ready_due", {31'd0, ia3.ready_o}, 32'd1);
                    void'(qa.pop_front());
                end
            end
            if (ib3.ready_o) begin
                if (qb.size() == 0) begin
                    chk("b_unexpected_ready", {31'd0, ib3.ready_o}, 32'd0);
                end else begin
                    e = qb.pop_front();
                    chk("b_ready_cycle", cyc, e.cyc);
                    chk("b_err", {31'd0, ib3.err_o}, {31'd0, e.err});
                    if (e.chk) chk("b_rdata", ib3.rdata_o, e.rd);
                end
            end else begin
                chk("b_idle_err", {31'd0, ib3.err_o}, 32'd0);
                if (qb.size() > 0 && qb[0].cyc <= cyc) begin
                    chk("b_ready_due", {31'd0, ib3.ready_o}, 32'd1);
                    void'(qb.pop_front());
                end
            end
        end
    end

    // Records responses of the LATENCY=4 instance during the reset scenario
    always @(negedge clk) begin
        if (mon4_en && ia4.ready_o === 1'b1) begin
            r4_cyc.push_back(cyc);
            r4_dat.push_back(ia4.rdata_o);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        vt[0]  = '{1'b1, 32'h000, 32'hCAFEF00D, 4'hF, 1'b1, 32'h080, 32'h11223344, 4'hF,
                   1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0};
        vt[1]  = '{1'b1, 32'h100, 32'h00000000, 4'hF, 1'b1, 32'h004, 32'h01020304, 4'hF,
                   1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0};
        vt[2]  = '{1'b1, 32'h000, 32'h0, 4'h0, 1'b1, 32'h080, 32'h0, 4'h0,
                   1'b1, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 1'b0, 1'b1, 32'h11223344, 32'h11223344, 1'b0};
        vt[3]  = '{1'b1, 32'h080, 32'hAAAAAAAA, 4'h3, 1'b1, 32'h080, 32'hBBBBBBBB, 4'h6,
                   1'b1, 32'h11223344, 32'h11BBBBAA, 1'b0, 1'b1, 1'b1, 32'h11223344, 32'h11BBBBAA, 1'b0};
        vt[4]  = '{1'b1, 32'h080, 32'h0, 4'h0, 1'b1, 32'h082, 32'h0, 4'h0,
                   1'b1, 32'h11BBBBAA, 32'h11BBBBAA, 1'b0, 1'b0, 1'b1, 32'h11BBBBAA, 32'h11BBBBAA, 1'b0};
        vt[5]  = '{1'b1, 32'h1000, 32'h5, 4'hF, 1'b1, 32'h000, 32'h0, 4'h0,
                   1'b1, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0};
        vt[6]  = '{1'b1, 32'h000, 32'h0, 4'h0, 1'b1, 32'hFFFFFFF0, 32'h0, 4'h0,
                   1'b1, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1};
        vt[7]  = '{1'b1, 32'h100, 32'h12345678, 4'hF, 1'b1, 32'h100, 32'h0, 4'h0,
                   1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h12345678, 1'b0};
        vt[8]  = '{1'b1, 32'h100, 32'h0, 4'h0, 1'b1, 32'h100, 32'hFF000000, 4'h8,
                   1'b1, 32'h12345678, 32'hFF345678, 1'b0, 1'b0, 1'b1, 32'h12345678, 32'h12345678, 1'b0};
        vt[9]  = '{1'b1, 32'h004, 32'hA5A5A5A5, 4'hF, 1'b1, 32'h008, 32'h5A5A5A5A, 4'hF,
                   1'b1, 32'h01020304, 32'h01020304, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0};
        vt[10] = '{1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h004, 32'h0, 4'h0,
                   1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0};
        vt[11] = '{1'b1, 32'h008, 32'h0, 4'h0, 1'b1, 32'h100, 32'h0, 4'h0,
                   1'b1, 32'h5A5A5A5A, 32'h5A5A5A5A, 1'b0, 1'b0, 1'b1, 32'hFF345678, 32'hFF345678, 1'b0};

        rst3 = 1'b1; rst4 = 1'b1;
        ia3.valid_i = 1'b0; ia3.addr_i = 32'h0; ia3.wdata_i = 32'h0; ia3.we_i = 4'h0;
        ib3.valid_i = 1'b0; ib3.addr_i = 32'h0; ib3.wdata_i = 32'h0; ib3.we_i = 4'h0;
        ia4.valid_i = 1'b0; ia4.addr_i = 32'h0; ia4.wdata_i = 32'h0; ia4.we_i = 4'h0;
        ib4.valid_i = 1'b0; ib4.addr_i = 32'h0; ib4.wdata_i = 32'h0; ib4.we_i = 4'h0;
        repeat (3) tick();
        chk("rst_a_flags", {29'd0, ia3.ready_o, ia3.err_o, coll3}, 32'd0);
        chk("rst_a_rdata", ia3.rdata_o, 32'd0);
        chk("rst_b_flags", {30'd0, ib3.ready_o, ib3.err_o}, 32'd0);
        chk("rst_b_rdata", ib3.rdata_o, 32'd0);
        chk("rst4_flags", {29'd0, ia4.ready_o, ia4.err_o, coll4}, 32'd0);
        chk("rst4_rdata", ia4.rdata_o, 32'd0);
        rst3 = 1'b0; rst4 = 1'b0;

        // Table vectors back to back at full rate, first one on the first edge out of reset
        for (int i = 0; i < 12; i++) drv3(vt[i]);

        // Write then read word 4 on consecutive cycles: readies at +3 and +4
        drv3('{1'b1, 32'h010, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, 32'h0, 4'h0,
               1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0});
        drv3('{1'b1, 32'h010, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0,
               1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0});

        for (int i = 0; i < 20; i++) begin
            if (qa.size() == 0 && qb.size() == 0) break;
            tick();
        end
        chk("drain_outstanding", qa.size() + qb.size(), 32'd0);
        repeat (3) tick();
        chk("a_rdata_hold", ia3.rdata_o, 32'hDEADBEEF);
        chk("b_rdata_hold", ib3.rdata_o, 32'hFF345678);

        // LATENCY=4: reset two cycles after a read is accepted drops its response
        ia4.valid_i = 1'b1; ia4.addr_i = 32'h030; ia4.wdata_i = 32'h0BADF00D; ia4.we_i = 4'hF;
        tick();
        ia4.valid_i = 1'b0;
        repeat (5) tick();
        mon4_en = 1'b1;
        ia4.valid_i = 1'b1; ia4.we_i = 4'h0;
        n = cyc;
        tick();
        ia4.valid_i = 1'b0;
        tick();
        rst4 = 1'b1;
        ia4.valid_i = 1'b1; ia4.wdata_i = 32'hFFFFFFFF; ia4.we_i = 4'hF;
        tick();
        chk("rst4_mid_ready", {31'd0, ia4.ready_o}, 32'd0);
        chk("rst4_mid_rdata", ia4.rdata_o, 32'd0);
        rst4 = 1'b0;
        ia4.we_i = 4'h0;
        tick();
        ia4.valid_i = 1'b0;
        repeat (8) tick();
        mon4_en = 1'b0;
        chk("rst4_ready_count", r4_cyc.size(), 32'd1);
        if (r4_cyc.size() > 0) begin
            chk("rst4_ready_cycle", r4_cyc[0], n + 7);
            chk("rst4_rdata", r4_dat[0], 32'h0BADF00D);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
